baud_gen_frac: RTL and testbench

Parametrised fractional baud/oversample timing generator, successor to the fixed-divider baud unit. It produces three single-cycle strobes for the UART TX and RX paths:
- an oversample tick;
- a mid-bit sample strobe;
- a bit-boundary strobe.

The divisor has an integer and a fractional part, is runtime-loadable, and the phase can be resynchronised by RX on a start-bit edge.

---
 rtl/baud_gen_frac_if.sv | 37 +++
 rtl/baud_gen_frac.sv | 103 ++++++++++
 tb/tb_baud_gen_frac.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_gen_frac_if.sv
// Divisor/control inputs and timing strobes of the fractional
// baud generator, bundled for the UART TX/RX paths.
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              enable;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              resync;
  logic              os_tick;
  logic              sample_tick;
  logic              bit_tick;

  modport master (
    output enable,
    output div_int,
    output div_frac,
    output div_load,
    output resync,
    input  os_tick,
    input  sample_tick,
    input  bit_tick
  );

  modport slave (
    input  enable,
    input  div_int,
    input  div_frac,
    input  div_load,
    input  resync,
    output os_tick,
    output sample_tick,
    output bit_tick
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample, mid-bit and bit strobes
// from an integer.fraction clocks-per-tick divisor.
module baud_gen_frac #(
  parameter int SYSTEM_CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE         = 115200,
  parameter int OVERSAMPLE        = 16,
  parameter int DIV_W             = 16,
  parameter int FRAC_W            = 4
) (
  input logic            clk,
  input logic            reset_n,
  baud_gen_frac_if.slave bus
);
  localparam int OS_W = $clog2(OVERSAMPLE);

  localparam logic [63:0] DEF =
    (64'(SYSTEM_CLOCK_FREQ) << FRAC_W) /
    (64'(BAUD_RATE) * 64'(OVERSAMPLE));

  localparam logic [DIV_W-1:0] DEF_INT =
    DIV_W'(DEF >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC =
    FRAC_W'(DEF);

  localparam logic [OS_W-1:0] OS_MID =
    OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST =
    OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  div_int_reg;
  logic [FRAC_W-1:0] frac_reg;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [OS_W-1:0]   os_cnt;
  logic              os_q;
  logic              sample_q;
  logic              bit_q;

  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  cnt_last;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;

  // Period is div_eff + carry, so the last count is div_eff-1+carry.
  always_comb begin
    div_eff  = (div_int_reg < DIV_W'(2)) ?
               DIV_W'(2) : div_int_reg;
    cnt_last = div_eff - DIV_W'(1) + DIV_W'(carry);
    acc_sum  = {1'b0, acc} + {1'b0, frac_reg};
    wrap     = (cnt == cnt_last);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_int_reg <= DEF_INT;
      frac_reg    <= DEF_FRAC;
      cnt         <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      os_cnt      <= '0;
      os_q        <= 1'b0;
      sample_q    <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      os_q     <= 1'b0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      if (bus.div_load || bus.resync) begin
        if (bus.div_load) begin
          div_int_reg <= bus.div_int;
          frac_reg    <= bus.div_frac;
        end
        cnt    <= '0;
        acc    <= '0;
        carry  <= 1'b0;
        os_cnt <= '0;
      end else if (bus.enable) begin
        if (wrap) begin
          cnt   <= '0;
          acc   <= acc_sum[FRAC_W-1:0];
          carry <= acc_sum[FRAC_W];
          os_q  <= 1'b1;
          if (os_cnt == OS_MID) begin
            sample_q <= 1'b1;
          end
          if (os_cnt == OS_LAST) begin
            os_cnt <= '0;
            bit_q  <= 1'b1;
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

  assign bus.os_tick     = os_q;
  assign bus.sample_tick = sample_q;
  assign bus.bit_tick    = bit_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Randomized bench for baud_gen_frac against a closed-form
// tick-time model: tick k lands at k*P + floor((k-1)*frac/2^F).
module tb_baud_gen_frac;
  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OS       = 16;
  localparam int DEF_INT  = 54;
  localparam int DEF_FRAC = 4;

  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_eff;
  int m_frac;
  int m_en;
  int m_k;
  logic [2:0] exp_vec;
  logic [2:0] got;

  baud_gen_frac_if #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W)
  ) bus ();

  baud_gen_frac #(
    .SYSTEM_CLOCK_FREQ(100000000),
    .BAUD_RATE(115200),
    .OVERSAMPLE(OS),
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign got = {bus.os_tick, bus.sample_tick, bus.bit_tick};

  // Enabled-edge time of the k-th oversample tick after a clear.
  function automatic int t_of(int k);
    return k * m_eff + ((k - 1) * m_frac) / (1 << FRAC_W);
  endfunction

  task automatic clear_model(int dint, int dfrac);
    m_eff   = (dint < 2) ? 2 : dint;
    m_frac  = dfrac;
    m_en    = 0;
    m_k     = 1;
    exp_vec = 3'b000;
  endtask

  task automatic adv();
    logic en;
    en = bus.enable;
    @(posedge clk);
    #1;
    cyc++;
    exp_vec = 3'b000;
    if (en) begin
      m_en++;
      if (m_en == t_of(m_k)) begin
        exp_vec[2] = 1'b1;
        exp_vec[1] = (m_k % OS) == OS / 2;
        exp_vec[0] = (m_k % OS) == 0;
        m_k++;
      end
    end
  endtask

  task automatic clear_edge(logic ld, logic rs,
                            int dint, int dfrac);
    bus.div_load = ld;
    bus.resync   = rs;
    if (ld) begin
      bus.div_int  = DIV_W'(dint);
      bus.div_frac = FRAC_W'(dfrac);
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    if (ld) clear_model(dint, dfrac);
    else clear_model(m_eff, m_frac);
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.enable   = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.div_load = 1'b0;
    bus.resync   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got !== 3'b000)
      $display("FAIL reset_strobes: got %b expected 000", got);
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (got !== 3'b000)
      $display("FAIL reset_enabled: got %b expected 000", got);
    if (got !== 3'b000) errors++;
    reset_n = 1'b1;
    clear_model(DEF_INT, DEF_FRAC);
  endtask

  task automatic test_default();
    int tq[$];
    int ns;
    int nb;
    ns = 0;
    nb = 0;
    for (int i = 1; i <= 1800; i++) begin
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL default_strobes: got %b expected %b cyc %0d",
                 got, exp_vec, i);
      end
      if (got[2]) tq.push_back(i);
      if (got[1]) ns++;
      if (got[0]) nb++;
    end
    checks++;
    if (tq.size() < 33) begin
      errors++;
      $display("FAIL default_tick_count: got %0d expected >=33",
               tq.size());
    end else begin
      checks += 3;
      if (tq[0] !== 54) begin
        errors++;
        $display("FAIL default_first_tick: got %0d expected 54", tq[0]);
      end
      if (tq[16] - tq[0] !== 868) begin
        errors++;
        $display("FAIL default_window1: got %0d expected 868",
                 tq[16] - tq[0]);
      end
      if (tq[32] - tq[16] !== 868) begin
        errors++;
        $display("FAIL default_window2: got %0d expected 868",
                 tq[32] - tq[16]);
      end
    end
    checks += 2;
    if (ns !== 2) begin
      errors++;
      $display("FAIL default_samples: got %0d expected 2", ns);
    end
    if (nb !== 2) begin
      errors++;
      $display("FAIL default_bits: got %0d expected 2", nb);
    end
  endtask

  task automatic test_load();
    int di;
    int df;
    int ncyc;
    int tq[$];
    for (int n = 0; n < 6; n++) begin
      case (n)
        0: begin di = 4; df = 8; end
        1: begin di = 4; df = 0; end
        2: begin di = 1; df = 0; end
        default: begin
          di = $urandom_range(0, 20);
          df = $urandom_range(0, 15);
        end
      endcase
      tq.delete();
      clear_edge(1'b1, 1'b0, di, df);
      checks++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL load_edge: got %b expected 000 int %0d", got, di);
      end
      ncyc = 34 * (m_eff + 1) + 4;
      for (int i = 1; i <= ncyc; i++) begin
        adv();
        checks++;
        if (got !== exp_vec) begin
          errors++;
          $display("FAIL load_strobes: got %b expected %b int %0d frac %0d cyc %0d",
                   got, exp_vec, di, df, i);
        end
        if (got[2]) tq.push_back(i);
      end
      checks++;
      if (tq.size() < 17) begin
        errors++;
        $display("FAIL load_tick_count: got %0d expected >=17", tq.size());
      end else if (tq[16] - tq[0] !== 16 * m_eff + df) begin
        errors++;
        $display("FAIL load_window: got %0d expected %0d",
                 tq[16] - tq[0], 16 * m_eff + df);
      end
      if (n == 2) begin
        checks++;
        if (tq.size() < 2 || tq[1] - tq[0] !== 2) begin
          errors++;
          $display("FAIL load_clamp: got %0d expected 2",
                   tq.size() < 2 ? -1 : tq[1] - tq[0]);
        end
      end
    end
  endtask

  task automatic test_resync();
    int di;
    int df;
    int fs;
    int fb;
    for (int n = 0; n < 2; n++) begin
      di = $urandom_range(3, 12);
      df = (n == 0) ? 0 : $urandom_range(1, 15);
      clear_edge(1'b1, 1'b0, di, df);
      for (int i = 0; i < 4000 && m_en + 1 < t_of(12); i++) begin
        adv();
        checks++;
        if (got !== exp_vec) begin
          errors++;
          $display("FAIL resync_pre: got %b expected %b", got, exp_vec);
        end
      end
      // Next edge would be the 12th tick; resync must suppress it.
      clear_edge(1'b0, 1'b1, 0, 0);
      checks++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL resync_wrap: got %b expected 000", got);
      end
      fs = -1;
      fb = -1;
      for (int i = 1; i <= 17 * (di + 1); i++) begin
        adv();
        checks++;
        if (got !== exp_vec) begin
          errors++;
          $display("FAIL resync_post: got %b expected %b cyc %0d",
                   got, exp_vec, i);
        end
        if (got[1] && fs < 0) fs = i;
        if (got[0] && fb < 0) fb = i;
      end
      if (n == 0) begin
        checks += 2;
        if (fs !== 8 * di) begin
          errors++;
          $display("FAIL resync_sample: got %0d expected %0d", fs, 8 * di);
        end
        if (fb !== 16 * di) begin
          errors++;
          $display("FAIL resync_bit: got %0d expected %0d", fb, 16 * di);
        end
      end
    end
    bus.enable = 1'b0;
    repeat (5) begin
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL resync_idle: got %b expected %b", got, exp_vec);
      end
    end
    clear_edge(1'b0, 1'b1, 0, 0);
    repeat (3) adv();
    bus.enable = 1'b1;
    di = $urandom_range(2, 9);
    df = $urandom_range(0, 15);
    clear_edge(1'b1, 1'b1, di, df);
    for (int i = 1; i <= 18 * (m_eff + 1); i++) begin
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL resync_load_both: got %b expected %b cyc %0d",
                 got, exp_vec, i);
      end
    end
  endtask

  task automatic test_enable();
    int t3;
    t3 = -1;
    clear_edge(1'b1, 1'b0, 10, 0);
    for (int i = 1; i <= 60; i++) begin
      bus.enable = !(i > 25 && i <= 35);
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL enable_pause: got %b expected %b cyc %0d",
                 got, exp_vec, i);
      end
      if (got[2] && m_k == 4) t3 = i;
    end
    checks++;
    if (t3 !== 40) begin
      errors++;
      $display("FAIL enable_stretch: got %0d expected 40", t3);
    end
    clear_edge(1'b1, 1'b0, $urandom_range(2, 8),
               $urandom_range(0, 15));
    for (int i = 1; i <= 800; i++) begin
      bus.enable = ($urandom_range(0, 3) != 0);
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL enable_random: got %b expected %b cyc %0d",
                 got, exp_vec, i);
      end
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    clear_edge(1'b1, 1'b0, 5, 3);
    for (int i = 0; i < 100 && !got[2]; i++) begin
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_pre: got %b expected %b", got, exp_vec);
      end
    end
    checks++;
    if (got[2] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_tick: got %b expected 1", got[2]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected 000", got);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_model(DEF_INT, DEF_FRAC);
    for (int i = 1; i <= 120; i++) begin
      adv();
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_post: got %b expected %b cyc %0d",
                 got, exp_vec, i);
      end
      if (got[2] && first < 0) first = i;
    end
    checks++;
    if (first !== 54) begin
      errors++;
      $display("FAIL reset_mid_first: got %0d expected 54", first);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load();
    test_resync();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish expected finish by 5ms");
    $fatal(1, "timeout");
  end
endmodule
